uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- UART receive path; the counterpart of the team's serializer on the transmit side.
- Oversamples the asynchronous line by PRESCALE and detects the start bit.
- Shifts in DATAWIDTH data bits MSB first, matching the serializer's shift order.
- Checks optional parity and the stop bit, then presents the parallel word with a one-cycle valid pulse to the downstream register file/FIFO.

Parameters:
- DATAWIDTH, 8, data bits per frame
- PRESCALE, 8, clk cycles per bit; must be even and at least 4
- CNTWIDTH, 4, width of the prescale counter; must hold PRESCALE-1

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx_in  input  1  asynchronous serial line, idle high
- par_en  input  1  1 = frame carries a parity bit
- par_typ  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  DATAWIDTH  received word; holds its value until the next good frame
- data_valid  output  1  one-cycle pulse: P_DATA is new and error-free
- par_err  output  1  one-cycle pulse: parity mismatch
- stp_err  output  1  one-cycle pulse: stop bit sampled 0
- busy  output  1  high while FSM not in IDLE

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high on a clk edge applies reset.
- Reset values: P_DATA=0, data_valid=0, par_err=0, stp_err=0, busy=0, FSM=IDLE, counters=0.
- Synchronizer: rx_in passes through 2 flops, both reset to 1. Output rx_s feeds all logic.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s==0, go to START and set cnt=1. Define t0 as this cycle; it counts as tick 0 of the start bit.
- Counting: cnt increments every non-IDLE cycle and wraps PRESCALE-1 -> 0. Bit boundaries fall on the wrap.
- Sample point: cnt==PRESCALE/2, giving a single sample. Bit k (start bit = 0) is sampled at t0 + k*PRESCALE + PRESCALE/2.
- START: if the sample is 1, treat as a glitch, return to IDLE at once with no outputs. If 0, go to DATA at the wrap and latch par_en/par_typ. Changes on those inputs mid-frame are ignored.
- DATA: shift the sample in at the LSB (shift register <<1), so the first data bit received ends at the MSB. Bit counter runs 0..DATAWIDTH-1. After the last bit, at the wrap, go to PARITY if the latched par_en is 1, else STOP.
- PARITY: compare the sample with XOR(data) (even) or ~XOR(data) (odd). Store the mismatch flag. Go to STOP at the wrap.
- STOP: at the sample point, evaluate the frame and go to IDLE in the next cycle. The line stays high for the rest of the stop bit, so no false start is detected. Back-to-back frames are accepted.
- Evaluation, registered and visible the cycle after the stop sample:
  - Good frame: data_valid=1 and P_DATA updated.
  - Parity mismatch: par_err=1, no data_valid, P_DATA unchanged.
  - Stop bit 0: stp_err=1, no data_valid, P_DATA unchanged.
  - Both errors: both error pulses assert.
- Latency, DATAWIDTH=8, PRESCALE=8: data_valid in cycle t0+77 without parity, t0+85 with parity.
- Reset mid-frame: return to IDLE next edge; no partial output or error pulse.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit is a 2-of-3 majority of samples at cnt = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1. The decision is taken at PRESCALE/2+1, so every timing above shifts by +1 cycle (t0+78 / t0+86). The start-bit glitch check uses the majority value.
- Undefined: the single-sample behaviour above. No majority logic is synthesized.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP)
  - parity-type constants PAR_EVEN=0, PAR_ODD=1
  - localparam SAMPLE_POINT = PRESCALE/2
- Sub-module uart_rx_bit_sampler:
  - contains the prescale counter, the sample-strobe generation and the optional majority vote
  - outputs sample_bit, sample_stb and bit_end
- The FSM, shift register and checks stay in the top module.

Test Plan:
- Reset, then idle line: 0xA5 frame, no parity, PRESCALE=8 -> single data_valid at t0+77, P_DATA=0xA5, no errors, busy low after.
- par_en=1, par_typ=0: send 0x3C with parity bit 0 -> data_valid at t0+85, P_DATA=0x3C. Same frame with parity bit 1 -> par_err pulse, no data_valid, P_DATA still 0x3C.
- 0x81, no parity, stop bit driven 0 -> stp_err pulse at t0+77, no data_valid. A following correct frame of 0x42 -> data_valid, P_DATA=0x42.
- rx_in low for 3 clk only -> FSM returns to IDLE, no pulses. Then a valid frame of 0x11 -> received correctly.
- Two frames 0xFF then 0x00 with zero idle gap -> two data_valid pulses exactly 80 cycles apart, correct data.
- rst asserted during DATA of frame 0x5A -> all outputs 0 next cycle, no pulses. Next frame of 0x5A is received cleanly.
- With UART_RX_MAJORITY_EN: a 1-cycle glitch at mid-bit of a data bit -> P_DATA unaffected, data_valid at t0+78.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t   : receive FSM states (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/ODD : encoding of the par_typ input
//   SAMPLE_POINT : mid-bit sample position for the default prescale
//   sample_point : mid-bit sample position for any prescale value
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int unsigned PRESCALE_DEFAULT = 8;
    localparam int unsigned SAMPLE_POINT     = PRESCALE_DEFAULT / 2;

    function automatic int unsigned sample_point(input int unsigned prescale);
        return prescale / 2;
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_sampler
// Prescale counter and per-bit sample strobe for the UART receiver.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 vote around mid-bit,
// decision one cycle later than the single-sample build).
// Ports:
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_rx_s          : synchronized serial line
//   i_active        : receiver FSM is outside IDLE
//   i_start         : start edge seen in IDLE this cycle (tick 0 of start bit)
//   o_sample_bit    : sampled (or voted) bit value, valid with o_sample_stb
//   o_sample_stb    : one-cycle strobe at the bit decision point
//   o_bit_end       : last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned CNTWIDTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx_s,
    input  logic i_active,
    input  logic i_start,
    output logic o_sample_bit,
    output logic o_sample_stb,
    output logic o_bit_end
);

    localparam logic [CNTWIDTH-1:0] CNT_LAST = CNTWIDTH'(PRESCALE - 1);
    localparam logic [CNTWIDTH-1:0] CNT_MID  = CNTWIDTH'(sample_point(PRESCALE));

    logic [CNTWIDTH-1:0] r_cnt;

    // The start-detect cycle is tick 0, so the count resumes at 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_active) begin
            r_cnt <= i_start ? CNTWIDTH'(1) : '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNTWIDTH'(1);
        end
    end

    assign o_bit_end = i_active && (r_cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNTWIDTH-1:0] CNT_PRE  = CNTWIDTH'(sample_point(PRESCALE) - 1);
    localparam logic [CNTWIDTH-1:0] CNT_POST = CNTWIDTH'(sample_point(PRESCALE) + 1);

    logic r_s_pre;
    logic r_s_mid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_pre <= 1'b1;
            r_s_mid <= 1'b1;
        end else begin
            if (r_cnt == CNT_PRE) r_s_pre <= i_rx_s;
            if (r_cnt == CNT_MID) r_s_mid <= i_rx_s;
        end
    end

    // Third vote is the live line value at mid+1.
    assign o_sample_stb = i_active && (r_cnt == CNT_POST);
    assign o_sample_bit = (r_s_pre & r_s_mid) | (r_s_pre & i_rx_s) | (r_s_mid & i_rx_s);
`else
    assign o_sample_stb = i_active && (r_cnt == CNT_MID);
    assign o_sample_bit = i_rx_s;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// UART receive path: 2-flop synchronizer, start detect, MSB-first shift-in,
// optional parity check, stop check, one-cycle result pulses.
// Optional feature macro: UART_RX_MAJORITY_EN (see uart_rx_bit_sampler).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   rx_in       : asynchronous serial line, idle high
//   par_en      : frame carries a parity bit (latched per frame)
//   par_typ     : 0 even / 1 odd parity (latched per frame)
//   P_DATA      : last good word, held until the next good frame
//   data_valid  : pulse, P_DATA is new and error-free
//   par_err     : pulse, parity mismatch
//   stp_err     : pulse, stop bit sampled low
//   busy        : FSM outside IDLE
// -----------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned PRESCALE  = PRESCALE_DEFAULT,
    parameter int unsigned CNTWIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 par_en,
    input  logic                 par_typ,
    output logic [DATAWIDTH-1:0] P_DATA,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 stp_err,
    output logic                 busy
);

    localparam int unsigned BITCNT_W = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(DATAWIDTH - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic [BITCNT_W-1:0]  r_bit_cnt;
    logic [DATAWIDTH-1:0] r_shift;
    logic                 r_par_en_l;
    logic                 r_par_typ_l;
    logic                 r_par_mis;
    logic                 w_active;
    logic                 w_start;
    logic                 w_bit;
    logic                 w_stb;
    logic                 w_bit_end;
    logic                 w_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s   = r_sync2;
    assign w_active = (r_state != IDLE);
    assign w_start  = (r_state == IDLE) && !w_rx_s;
    assign busy     = w_active;

    uart_rx_bit_sampler #(
        .PRESCALE (PRESCALE),
        .CNTWIDTH (CNTWIDTH)
    ) u_sampler (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_s       (w_rx_s),
        .i_active     (w_active),
        .i_start      (w_start),
        .o_sample_bit (w_bit),
        .o_sample_stb (w_stb),
        .o_bit_end    (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE:   if (!w_rx_s) w_next_state = START;
            // A high start sample is a glitch; abandon before the bit ends.
            START:  if (w_stb && w_bit)  w_next_state = IDLE;
                    else if (w_bit_end)  w_next_state = DATA;
            DATA:   if (w_bit_end && (r_bit_cnt == LAST_BIT))
                        w_next_state = r_par_en_l ? PARITY : STOP;
            PARITY: if (w_bit_end) w_next_state = STOP;
            // Leave at the stop sample; the rest of the stop bit is idle-high.
            STOP:   if (w_stb) begin
                        w_next_state = IDLE;
                        w_frame_done = 1'b1;
                    end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_en_l  <= 1'b0;
            r_par_typ_l <= 1'b0;
            r_par_mis   <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if ((r_state == START) && (w_next_state == DATA)) begin
                r_par_en_l  <= par_en;
                r_par_typ_l <= par_typ;
                r_par_mis   <= 1'b0;
                r_bit_cnt   <= '0;
            end

            if (r_state == DATA) begin
                if (w_stb) r_shift <= (r_shift << 1) | DATAWIDTH'(w_bit);
                if (w_bit_end)
                    r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BITCNT_W'(1);
            end

            if ((r_state == PARITY) && w_stb)
                r_par_mis <= w_bit ^ (^r_shift) ^ (r_par_typ_l != PAR_EVEN);

            if (w_frame_done) begin
                par_err <= r_par_mis;
                stp_err <= !w_bit;
                if (!r_par_mis && w_bit) begin
                    data_valid <= 1'b1;
                    P_DATA     <= r_shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

    localparam int unsigned DW = 8;
    localparam int unsigned PS = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          par_en;
    logic          par_typ;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx_deserializer #(
        .DATAWIDTH (DW),
        .PRESCALE  (PS),
        .CNTWIDTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          dv;
        logic          pe;
        logic          se;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            dv_cycs[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] model_pdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid || par_err || stp_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'b0, data_valid, par_err, stp_err}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("data_valid", data_valid, e.dv);
                chk("par_err", par_err, e.pe);
                chk("stp_err", stp_err, e.se);
                chk("P_DATA", P_DATA, e.data);
                chk("latency_cycle", cyc, e.cyc);
            end
            if (data_valid) dv_cycs.push_back(cyc);
        end
    end

    // All drive tasks start and end #1 after a rising edge.
    task automatic drive_bit(input logic b, input logic glitch);
        for (int c = 0; c < int'(PS); c++) begin
            rx_in = (glitch && c == int'(PS / 2)) ? ~b : b;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pflip,
                              input logic stop_b, input int gbit);
        exp_t e;
        logic pbit;
        int   k;
        e.pe = par_en & pflip;
        e.se = ~stop_b;
        e.dv = !e.pe && !e.se;
        if (e.dv) model_pdata = d;
        e.data = model_pdata;
        // 2 sync cycles + frame latency (+8 with parity, +1 with vote)
        e.cyc = cyc + 2 + 77 + (par_en ? 8 : 0) + MAJ;
        sb.push_back(e);
        pbit = (^d) ^ par_typ ^ pflip;
        drive_bit(1'b0, gbit == 0);
        k = 1;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            drive_bit(d[i], gbit == k);
            k++;
        end
        if (par_en) drive_bit(pbit, 1'b0);
        drive_bit(stop_b, 1'b0);
        rx_in = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk(tag, sb.size(), 32'h0);
    endtask

    int i0;

    initial begin
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_typ = 1'b0;
        model_pdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_P_DATA", P_DATA, 32'h0);
        chk("rst_data_valid", data_valid, 32'h0);
        chk("rst_par_err", par_err, 32'h0);
        chk("rst_stp_err", stp_err, 32'h0);
        chk("rst_busy", busy, 32'h0);
        rst = 1'b0;
        idle(10);

        send_frame(8'hA5, 1'b0, 1'b1, -1);
        idle(5); drain("drain_a5");
        chk("busy_after_a5", busy, 32'h0);

        par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        idle(5); drain("drain_3c_even");
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle(5); drain("drain_3c_bad_par");
        chk("pdata_hold_par_err", P_DATA, 32'h3C);
        par_typ = 1'b1;
        send_frame(8'h3D, 1'b0, 1'b1, -1);
        idle(5); drain("drain_3d_odd");

        par_en = 1'b0; par_typ = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, -1);
        idle(20); drain("drain_81_stop0");
        chk("pdata_hold_stp_err", P_DATA, 32'h3D);
        send_frame(8'h42, 1'b0, 1'b1, -1);
        idle(5); drain("drain_42");

        rx_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rx_in = 1'b1;
        chk("glitch_busy_high", busy, 32'h1);
        idle(20);
        chk("glitch_busy_low", busy, 32'h0);
        chk("glitch_no_pulse", sb.size(), 32'h0);
        send_frame(8'h11, 1'b0, 1'b1, -1);
        idle(5); drain("drain_11");

        i0 = dv_cycs.size();
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        send_frame(8'h00, 1'b0, 1'b1, -1);
        idle(5); drain("drain_b2b");
        chk("b2b_pulse_count", dv_cycs.size() - i0, 32'd2);
        if (dv_cycs.size() >= i0 + 2)
            chk("b2b_gap", dv_cycs[i0 + 1] - dv_cycs[i0], 32'd80);

        // 0x5A truncated after three data bits (0,1,0), then reset.
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        chk("midframe_busy", busy, 32'h1);
        rst = 1'b1; rx_in = 1'b1;
        @(posedge clk); #1;
        chk("midrst_P_DATA", P_DATA, 32'h0);
        chk("midrst_data_valid", data_valid, 32'h0);
        chk("midrst_par_err", par_err, 32'h0);
        chk("midrst_stp_err", stp_err, 32'h0);
        chk("midrst_busy", busy, 32'h0);
        model_pdata = '0;
        rst = 1'b0;
        idle(20);
        chk("post_rst_no_pulse", sb.size(), 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        idle(5); drain("drain_5a");

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h96, 1'b0, 1'b1, 3);
        idle(5); drain("drain_96_vote");
        chk("vote_P_DATA", P_DATA, 32'h96);
`endif

        idle(10);
        drain("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
